joystick_dir_queue: RTL and testbench

- Parametrised successor to the snake's joystick direction decoder.
- Synchronises and debounces the four raw resistor-ladder lines, then turns each newly pressed single direction into an event.
- Rejects 180° reversals against the last accepted direction and buffers accepted turns in a small FIFO.
- The game-tick logic pops one turn per snake step, so two quick presses inside one step are both kept, in order.

---
 rtl/joystick_dir_queue_pkg.sv | 27 ++
 rtl/joystick_dir_queue_input_debounce.sv | 54 +++++
 rtl/joystick_dir_queue.sv | 105 ++++++++++
 tb/tb_joystick_dir_queue.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/joystick_dir_queue_pkg.sv
// Shared definitions for the joystick turn queue: direction codes, the
// reversal helper and the idle levels of the resistor-ladder lines.
package joystick_dir_queue_pkg;

  localparam int unsigned DIR_W   = 2;
  localparam int unsigned LINES_W = 4;

  typedef enum logic [DIR_W-1:0] {
    TOP_DIR   = 2'b00,
    RIGHT_DIR = 2'b01,
    DOWN_DIR  = 2'b10,
    LEFT_DIR  = 2'b11
  } dir_t;

  // Idle (released) level of each ladder line type.
  localparam logic ONE_RESISTOR_IDLE  = 1'b1;
  localparam logic TWO_RESISTORS_IDLE = 1'b0;

  // Line vector order matches the direction codes: {left, down, right, up}.
  localparam logic [LINES_W-1:0] LINES_IDLE = {TWO_RESISTORS_IDLE, ONE_RESISTOR_IDLE,
                                               ONE_RESISTOR_IDLE, TWO_RESISTORS_IDLE};

  function automatic dir_t opposite(input dir_t d);
    return dir_t'(DIR_W'(d ^ 2'b10));
  endfunction

endpackage

// File: rtl/joystick_dir_queue_input_debounce.sv
// Two-flop synchroniser plus one shared stable-counter debouncer over a
// vector of lines; the output is the decoded "pressed" vector.
module joystick_dir_queue_input_debounce #(
  parameter int unsigned    WIDTH           = 4,
  parameter int unsigned    DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] IDLE_LEVEL    = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] debounced,
  output logic             changed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_1;
  logic [WIDTH-1:0] sync_2;
  logic [WIDTH-1:0] candidate;
  logic [CNT_W-1:0] stable_cnt;
  logic [WIDTH-1:0] pressed_c;

  // A line reads as pressed whenever it sits away from its idle level.
  assign pressed_c = sync_2 ^ IDLE_LEVEL;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1     <= IDLE_LEVEL;
      sync_2     <= IDLE_LEVEL;
      candidate  <= '0;
      stable_cnt <= '0;
      debounced  <= '0;
      changed    <= 1'b0;
    end else begin
      sync_1  <= raw;
      sync_2  <= sync_1;
      changed <= 1'b0;
      if (pressed_c != candidate) begin
        candidate  <= pressed_c;
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        // Counter holds here until the candidate moves again.
        if (debounced != candidate) begin
          debounced <= candidate;
          changed   <= 1'b1;
        end
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/joystick_dir_queue.sv
// Joystick direction decoder with reversal rejection and a small turn FIFO
// drained one entry per game step.
module joystick_dir_queue
  import joystick_dir_queue_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter logic [1:0]  INIT_DIR        = 2'b00
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           one_resistor_x,
  input  logic                           two_resistors_x,
  input  logic                           one_resistor_y,
  input  logic                           two_resistors_y,
  input  logic                           step,
  output logic [1:0]                     direction,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
  output logic                           dropped
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QUEUE_DEPTH);

  logic [LINES_W-1:0] raw_lines;
  logic [LINES_W-1:0] pressed;
  logic               pressed_changed;

  dir_t               queue_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W-1:0]   tail_prev_c;

  dir_t               event_dir_c;
  logic               event_c;
  dir_t               ref_dir_c;
  logic               accept_c;
  logic               full_c;
  logic               pop_c;
  logic               push_c;

  assign raw_lines = {two_resistors_x, one_resistor_y, one_resistor_x, two_resistors_y};

  joystick_dir_queue_input_debounce #(
    .WIDTH           (LINES_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .IDLE_LEVEL      (LINES_IDLE)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .raw       (raw_lines),
    .debounced (pressed),
    .changed   (pressed_changed)
  );

  // Only a single pressed direction forms a turn event.
  always_comb begin
    event_dir_c = TOP_DIR;
    case (pressed)
      4'b0001: event_dir_c = TOP_DIR;
      4'b0010: event_dir_c = RIGHT_DIR;
      4'b0100: event_dir_c = DOWN_DIR;
      4'b1000: event_dir_c = LEFT_DIR;
      default: event_dir_c = TOP_DIR;
    endcase
  end

  assign event_c = pressed_changed && $onehot(pressed);

  // New turns are judged against the newest queued turn, not the snake.
  assign tail_prev_c = tail - PTR_W'(1);
  assign ref_dir_c   = (queue_count != '0) ? queue_mem[tail_prev_c] : dir_t'(direction);
  assign accept_c    = event_c && (event_dir_c != ref_dir_c)
                                && (event_dir_c != opposite(ref_dir_c));
  assign full_c      = (queue_count == CNT_FULL);
  assign pop_c       = step && (queue_count != '0);
  assign push_c      = accept_c && (!full_c || pop_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      queue_count <= '0;
      direction   <= INIT_DIR;
      dropped     <= 1'b0;
    end else begin
      dropped <= accept_c && full_c && !pop_c;
      if (push_c) begin
        queue_mem[tail] <= event_dir_c;
        tail            <= tail + PTR_W'(1);
      end
      if (pop_c) begin
        direction <= queue_mem[head];
        head      <= head + PTR_W'(1);
      end
      if (push_c && !pop_c) begin
        queue_count <= queue_count + CNT_W'(1);
      end else if (pop_c && !push_c) begin
        queue_count <= queue_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_joystick_dir_queue.sv
// Bench for joystick_dir_queue: directed table of hold/step records plus
// randomized presses checked cycle by cycle against a queue-based model.
module tb_joystick_dir_queue;

  localparam int unsigned DC = 4;
  localparam int unsigned QD = 4;

  localparam logic [3:0] P_IDLE = 4'b0000;
  localparam logic [3:0] P_UP   = 4'b0001;
  localparam logic [3:0] P_RT   = 4'b0010;
  localparam logic [3:0] P_DN   = 4'b0100;
  localparam logic [3:0] P_LT   = 4'b1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       one_resistor_x, two_resistors_x, one_resistor_y, two_resistors_y;
  logic       step;
  logic [1:0] direction;
  logic [2:0] queue_count;
  logic       dropped;

  joystick_dir_queue #(
    .DEBOUNCE_CYCLES (DC),
    .QUEUE_DEPTH     (QD),
    .INIT_DIR        (2'b00)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .one_resistor_x  (one_resistor_x),
    .two_resistors_x (two_resistors_x),
    .one_resistor_y  (one_resistor_y),
    .two_resistors_y (two_resistors_y),
    .step            (step),
    .direction       (direction),
    .queue_count     (queue_count),
    .dropped         (dropped)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int drops_seen;

  // Reference model: inputs seen at recent edges, debounced level, queue.
  logic [3:0] hist [DC+3];
  logic [3:0] m_deb;
  bit         m_ev;
  logic [1:0] m_evdir;
  logic [1:0] mq [$];
  logic [1:0] m_dir;
  bit         m_drop;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DC + 3; i++) hist[i] = 4'b0000;
    m_deb = 4'b0000; m_ev = 0; m_evdir = 2'b00; m_dir = 2'b00; m_drop = 0;
    mq.delete();
  endtask

  // One clock edge of the specified behaviour, given the pre-edge inputs.
  task automatic model_edge(input logic [3:0] p, input bit st);
    bit         pop, accept, full, stable;
    logic [1:0] rf;
    logic [3:0] nd;
    pop    = st && (mq.size() > 0);
    rf     = (mq.size() > 0) ? mq[mq.size()-1] : m_dir;
    full   = (mq.size() == QD);
    accept = m_ev && (m_evdir != rf) && (m_evdir != (rf ^ 2'b10));
    m_drop = accept && full && !pop;
    if (pop) m_dir = mq.pop_front();
    if (accept && (!full || pop)) mq.push_back(m_evdir);
    // Debounced level follows the input once it was steady for DC+1 samples, two edges late.
    for (int i = 0; i < DC + 2; i++) hist[i] = hist[i+1];
    hist[DC+2] = p;
    stable = 1;
    for (int i = 1; i <= DC; i++) if (hist[i] != hist[0]) stable = 0;
    nd   = stable ? hist[DC] : m_deb;
    m_ev = (nd != m_deb) && ($countones(nd) == 1);
    for (int i = 0; i < 4; i++) if (nd[i]) m_evdir = 2'(i);
    m_deb = nd;
  endtask

  task automatic drive(input logic [3:0] p, input bit st);
    one_resistor_x  = ~p[1];
    two_resistors_x =  p[3];
    one_resistor_y  = ~p[2];
    two_resistors_y =  p[0];
    step            = st;
  endtask

  task automatic cycle(input logic [3:0] p, input bit st);
    drive(p, st);
    @(posedge clk);
    model_edge(p, st);
    #1;
    chk("model_direction", int'(direction), int'(m_dir));
    chk("model_count", int'(queue_count), mq.size());
    chk("model_dropped", int'(dropped), int'(m_drop));
    if (dropped) drops_seen++;
    drive(p, 1'b0);
  endtask

  task automatic do_reset();
    drive(P_IDLE, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    chk("reset_direction", int'(direction), 0);
    chk("reset_count", int'(queue_count), 0);
    chk("reset_dropped", int'(dropped), 0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] p;
    int         cyc;
    bit         st;
    int         e_dir;
    int         e_cnt;
    int         e_drops;
  } rec_t;

  rec_t tbl [$];

  function automatic void add(input logic [3:0] p, input int cyc, input bit st,
                              input int e_dir, input int e_cnt, input int e_drops);
    rec_t r;
    r.p = p; r.cyc = cyc; r.st = st; r.e_dir = e_dir; r.e_cnt = e_cnt; r.e_drops = e_drops;
    tbl.push_back(r);
  endfunction

  initial begin
    reset = 1'b1;
    drive(P_IDLE, 1'b0);
    repeat (2) @(posedge clk);
    do_reset();

    add(P_IDLE, 100, 1, 0, 0, 0);
    add(P_RT,     3, 0, 0, 0, 0);   // too short to pass the debouncer
    add(P_IDLE,  10, 0, 0, 0, 0);
    add(P_RT,    10, 0, 0, 1, 0);
    add(P_IDLE,  10, 1, 1, 0, 0);
    add(P_UP,    10, 0, 1, 1, 0);
    add(P_IDLE,  10, 1, 0, 0, 0);
    add(P_DN,    10, 0, 0, 0, 0);   // reversal
    add(P_IDLE,  10, 0, 0, 0, 0);
    add(P_UP,    10, 0, 0, 0, 0);   // same direction
    add(P_IDLE,  10, 0, 0, 0, 0);
    add(P_RT,    10, 0, 0, 1, 0);
    add(P_IDLE,  10, 0, 0, 1, 0);
    add(P_LT,    10, 0, 0, 1, 0);   // reversal of queued RIGHT
    add(P_IDLE,  10, 0, 0, 1, 0);
    add(P_DN,    10, 0, 0, 2, 0);
    add(P_IDLE,  10, 1, 1, 1, 0);
    add(P_IDLE,   1, 1, 2, 0, 0);
    add(P_LT,    10, 0, 2, 1, 0);
    add(P_IDLE,  10, 0, 2, 1, 0);
    add(P_UP,    10, 0, 2, 2, 0);
    add(P_IDLE,  10, 0, 2, 2, 0);
    add(P_RT,    10, 0, 2, 3, 0);
    add(P_IDLE,  10, 0, 2, 3, 0);
    add(P_DN,    10, 0, 2, 4, 0);
    add(P_IDLE,  10, 0, 2, 4, 0);
    add(P_LT,    10, 0, 2, 4, 1);   // overflow
    add(P_IDLE,  10, 0, 2, 4, 0);
    add(P_LT,     8, 1, 3, 4, 0);   // push lands on the pop edge
    add(P_IDLE,  10, 0, 3, 4, 0);
    add(P_LT | P_UP, 10, 0, 3, 4, 0);
    add(P_IDLE,  10, 0, 3, 4, 0);
    add(P_IDLE,   1, 1, 0, 3, 0);

    foreach (tbl[k]) begin
      drops_seen = 0;
      for (int c = 0; c < tbl[k].cyc; c++)
        cycle(tbl[k].p, tbl[k].st && (c == tbl[k].cyc - 1));
      chk($sformatf("tbl%0d_direction", k), int'(direction), tbl[k].e_dir);
      chk($sformatf("tbl%0d_count", k), int'(queue_count), tbl[k].e_cnt);
      chk($sformatf("tbl%0d_drops", k), drops_seen, tbl[k].e_drops);
    end

    // Reset with three turns queued discards them.
    do_reset();
    cycle(P_IDLE, 1'b1);
    chk("post_reset_step_direction", int'(direction), 0);
    chk("post_reset_step_count", int'(queue_count), 0);

    // Randomized holds and steps against the model.
    for (int s = 0; s < 300; s++) begin
      logic [3:0] p;
      int         mode, hold;
      mode = $urandom_range(0, 19);
      if (mode < 12)      p = 4'(1 << $urandom_range(0, 3));
      else if (mode < 17) p = P_IDLE;
      else                p = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 12);
      for (int c = 0; c < hold; c++) cycle(p, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 59) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
